// File: rtl/axo_fetch.sv
// Instruction fetch stage: one outstanding word read at a time, a small
// prefetch FIFO towards decode, redirect flushing and in-band fault entries.
module axo_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  input  logic        redirect,
  input  logic [31:1] redirect_pc,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic [31:1] insn_pc,
  output logic        insn_fault,
  output logic [1:0]  dbg_state
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        halted_q, halted_d;
  logic        discard_q, discard_d;
  logic        fpend_q, fpend_d;
  logic [31:1] fpc_q, fpc_d;

  logic [31:0] f_insn_q [DEPTH];
  logic [31:1] f_pc_q   [DEPTH];
  logic        f_flt_q  [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;

  logic        push, pop, misaligned;
  logic [31:0] push_insn;
  logic [31:1] push_pc;
  logic        push_flt;

  // Decode handshake: the head transfers on a cycle where insn_valid && insn_ready;
  // until then the head fields are held. A redirect flushes instead of popping.
  assign misaligned = redirect_pc[1];
  assign insn_valid = (count_q != '0);
  assign pop        = insn_valid && insn_ready && !redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    halted_d   = halted_q;
    discard_d  = discard_q;
    fpend_d    = 1'b0;
    fpc_d      = fpc_q;
    push       = 1'b0;
    push_insn  = '0;
    push_pc    = '0;
    push_flt   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!halted_q && (count_q < DEPTH_C) && !redirect) begin
          state_d    = S_REQ;
          req_addr_d = {fetch_pc_q[31:2], 2'b00};
        end
      end
      S_REQ: begin
        // A stale request is still completed so the address stays stable.
        discard_d = discard_q | redirect;
        if (mem_ready) begin
          state_d = S_WAIT;
          if (!discard_q && !redirect) fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          if (!discard_q && !redirect) begin
            push      = 1'b1;
            push_insn = mem_err ? 32'h0 : mem_rdata;
            push_pc   = req_addr_q[31:1];
            push_flt  = mem_err;
            if (mem_err) halted_d = 1'b1;
          end
        end else begin
          discard_d = discard_q | redirect;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The fault entry of a misaligned redirect lands one cycle after the flush.
    if (fpend_q) begin
      push      = 1'b1;
      push_insn = 32'h0;
      push_pc   = fpc_q;
      push_flt  = 1'b1;
    end

    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      halted_d   = misaligned;
      fpend_d    = misaligned;
      fpc_d      = redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_VEC;
      req_addr_q <= '0;
      halted_q   <= 1'b0;
      discard_q  <= 1'b0;
      fpend_q    <= 1'b0;
      fpc_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      halted_q   <= halted_d;
      discard_q  <= discard_d;
      fpend_q    <= fpend_d;
      fpc_q      <= fpc_d;
    end
  end

  // Issue is gated on occupancy, so a push never meets a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        f_insn_q[i] <= '0;
        f_pc_q[i]   <= '0;
        f_flt_q[i]  <= 1'b0;
      end
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        f_insn_q[wr_ptr_q] <= push_insn;
        f_pc_q[wr_ptr_q]   <= push_pc;
        f_flt_q[wr_ptr_q]  <= push_flt;
        wr_ptr_q           <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_q <= count_q + CNT_ONE;
      else if (pop && !push) count_q <= count_q - CNT_ONE;
    end
  end

  assign mem_req    = (state_q == S_REQ);
  assign mem_addr   = req_addr_q;
  assign insn       = insn_valid ? f_insn_q[rd_ptr_q] : 32'h0;
  assign insn_pc    = insn_valid ? f_pc_q[rd_ptr_q]   : 31'h0;
  assign insn_fault = insn_valid ? f_flt_q[rd_ptr_q]  : 1'b0;
  assign dbg_state  = state_q;

endmodule
